// File: rtl/load_ext_unit_pkg.sv
// Shared encodings for the load path: load-select codes (also used by the
// control decoder), load error codes and the load FSM state type.
package load_ext_unit_pkg;

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LB  = 3'd4;
    localparam logic [2:0] LD_LBU = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ADEL = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_SEL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } ld_state_e;

    function automatic logic sel_legal(input logic [2:0] sel);
        logic ok;
        case (sel)
            LD_LW, LD_LH, LD_LHU, LD_LB, LD_LBU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Word loads need a 4-byte aligned address, halfword loads a 2-byte one.
    function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] lo);
        logic bad;
        case (sel)
            LD_LW:         bad = (lo != 2'b00);
            LD_LH, LD_LHU: bad = lo[0];
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_ext_unit_lane.sv
// Combinational byte/halfword lane extraction with sign or zero extension
// of a read word according to the load select code.
module load_lane_ext
    import load_ext_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  sel,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected lane to 32 bits.
    always_comb begin
        case (sel)
            LD_LW:   data = word;
            LD_LH:   data = {{16{half_s[15]}}, half_s};
            LD_LHU:  data = {16'h0000, half_s};
            LD_LB:   data = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  data = {24'h000000, byte_s};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_ext_unit.sv
// Load unit: issues a word read on behalf of the MEM stage, waits for the
// acknowledge with a timeout, extends the addressed lane and pulses ld_done.
module load_ext_unit
    import load_ext_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_sel,
    input  logic        flush,
    output logic        ld_busy,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic [1:0]  ld_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ld_state_e        state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       err_q, err_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [31:0]      ext_s;

    load_lane_ext u_lane (
        .word    (bus_rdata),
        .addr_lo (lo_q),
        .sel     (sel_q),
        .data    (ext_s)
    );

    // Next-state, counter and result capture.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ld_valid && !flush) begin
                    sel_d = ld_sel;
                    lo_d  = ld_addr[1:0];
                    if (!sel_legal(ld_sel)) begin
                        err_d   = ERR_SEL;
                        state_d = ST_DONE;
                    end else if (misaligned(ld_sel, ld_addr[1:0])) begin
                        err_d   = ERR_ADEL;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = {ld_addr[31:2], 2'b00};
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An ack in the expiry cycle still wins over the timeout.
                if (bus_ack) begin
                    cnt_d = '0;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = ext_s;
                        err_d   = ERR_NONE;
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // Swallow the outstanding ack so it is not credited to the next load.
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_WAIT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            lo_q    <= 2'd0;
            cnt_q   <= '0;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            err_q   <= ERR_NONE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A flush during the DONE cycle must cancel the completion pulse itself.
    assign ld_done  = done_q & ~flush;
    assign ld_busy  = busy_q;
    assign ld_data  = data_q;
    assign ld_err   = err_q;
    assign bus_req  = req_q;
    assign bus_addr = addr_q;

endmodule
